// File: rtl/alu_operand_entry.sv
// alu_operand_entry: synchronizes and debounces switches/buttons and runs the opcode-then-operand entry sequence for the ALU
// Ports: clk, rst_n (async, active-low); sw[9:0], btn_enter, btn_clear raw asynchronous inputs;
//        opcode[5:0], operand[9:0] registered ALU operands; valid (committed pair); entry_state[1:0]
//        (00 OPCODE, 01 OPERAND, 10 RUN); err (one-cycle pulse on a rejected opcode)
module alu_operand_entry_db #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic settled,
  input  logic lvl,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic db, db_q, armed;
  // armed only once a genuine low has been seen after reset, so a button held through reset never fires
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      db <= 1'b0;
      db_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      db_q <= db;
      armed <= armed | (settled & ~db & ~lvl);
      if (lvl == db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db <= ~db;
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
  assign pulse = db & ~db_q & armed;
endmodule

module alu_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] sw,
  input  logic       btn_enter,
  input  logic       btn_clear,
  output logic [5:0] opcode,
  output logic [9:0] operand,
  output logic       valid,
  output logic [1:0] entry_state,
  output logic       err
);
  typedef enum logic [1:0] {OPCODE = 2'b00, OPERAND = 2'b01, RUN = 2'b10} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0][11:0] sync;
  logic [SYNC_STAGES-1:0] settle;
  logic [9:0] sw_s;
  logic ent_s, clr_s, ent_p, clr_p, one_hot;
  // settle marks when the synchronizer chain holds real samples again after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      settle <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], {btn_clear, btn_enter, sw}};
      settle <= {settle[SYNC_STAGES-2:0], 1'b1};
    end
  assign {clr_s, ent_s, sw_s} = sync[SYNC_STAGES-1];
  alu_operand_entry_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ent (
    .clk(clk), .rst_n(rst_n), .settled(settle[SYNC_STAGES-1]), .lvl(ent_s), .pulse(ent_p)
  );
  alu_operand_entry_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk(clk), .rst_n(rst_n), .settled(settle[SYNC_STAGES-1]), .lvl(clr_s), .pulse(clr_p)
  );
  assign one_hot = (sw_s[5:0] != 6'd0) && ((sw_s[5:0] & (sw_s[5:0] - 6'd1)) == 6'd0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= OPCODE;
      opcode <= '0;
      operand <= '0;
      valid <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= 1'b0;
      if (clr_p) begin
        state <= OPCODE;
        opcode <= '0;
        operand <= '0;
        valid <= 1'b0;
      end else
        case (state)
          OPCODE:
            if (ent_p) begin
              if (one_hot) begin
                opcode <= sw_s[5:0];
                state <= OPERAND;
              end else err <= 1'b1;
            end
          OPERAND:
            if (ent_p) begin
              operand <= sw_s;
              valid <= 1'b1;
              state <= RUN;
            end
          RUN:
            if (ent_p) begin
              valid <= 1'b0;
              state <= OPCODE;
            end
          default: state <= OPCODE;
        endcase
    end
  assign entry_state = state;
endmodule

// File: tb/tb_alu_operand_entry.sv
// tb_alu_operand_entry: scoreboard bench for the ALU operand entry front end
module tb_alu_operand_entry;
  logic clk = 0, rst_n;
  logic [9:0] sw = '0;
  logic btn_enter = 0, btn_clear = 0;
  logic [5:0] opcode;
  logic [9:0] operand;
  logic valid, err;
  logic [1:0] entry_state;

  alu_operand_entry #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn_enter(btn_enter), .btn_clear(btn_clear),
    .opcode(opcode), .operand(operand), .valid(valid), .entry_state(entry_state), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    logic [5:0] op;
    logic [9:0] opd;
    logic v;
    logic [1:0] st;
    logic e;
    int cyc;
  } exp_t;

  exp_t q[$];
  int cyc = 0, vectors = 0, miscompares = 0, probe_req = 0, probe_ack = 0;
  bit mon_en = 0, primed = 0;
  logic [19:0] cur, prev;
  exp_t ex;
  bit bseq [0:5] = '{1, 0, 1, 1, 0, 1};

  always @(posedge clk) cyc++;

  // any output change (or a forced probe) consumes one expected entry
  always @(negedge clk)
    if (mon_en) begin
      cur = {opcode, operand, valid, entry_state, err};
      if (!primed) primed = 1;
      else if (cur !== prev || probe_req != probe_ack) begin
        probe_ack = probe_req;
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected: outputs changed to %h at cycle %0d, required no change", cur, cyc);
        end else begin
          ex = q.pop_front();
          if (cur !== {ex.op, ex.opd, ex.v, ex.st, ex.e} || (ex.cyc >= 0 && ex.cyc != cyc)) begin
            miscompares++;
            $display("FAIL %s: got op=%h opd=%h v=%b st=%b err=%b cyc=%0d, required op=%h opd=%h v=%b st=%b err=%b cyc=%0d",
                     ex.nm, opcode, operand, valid, entry_state, err, cyc, ex.op, ex.opd, ex.v, ex.st, ex.e, ex.cyc);
          end
        end
      end
      prev = cur;
    end

  task automatic push(input string nm, input logic [5:0] op, input logic [9:0] opd,
                      input logic v, input logic [1:0] st, input logic e, input int c);
    exp_t t;
    t.nm = nm; t.op = op; t.opd = opd; t.v = v; t.st = st; t.e = e; t.cyc = c;
    q.push_back(t);
  endtask

  // clean press: raw change at a negedge commits 2 sync + 4 debounce + 1 FSM edges later
  task automatic step(input string nm, input logic [9:0] s, input logic e, input logic c,
                      input logic [5:0] op, input logic [9:0] opd, input logic v,
                      input logic [1:0] st, input bit rej);
    @(negedge clk);
    sw = s;
    push(nm, op, opd, v, st, rej, cyc + 7);
    if (rej) push({nm, "_drop"}, op, opd, v, st, 1'b0, cyc + 8);
    btn_enter = e;
    btn_clear = c;
    repeat (10) @(negedge clk);
    btn_enter = 0;
    btn_clear = 0;
    repeat (12) @(negedge clk);
  endtask

  task automatic reset_probe(input string nm);
    @(posedge clk);
    #2 rst_n = 0;
    push(nm, 6'h00, 10'h000, 1'b0, 2'b00, 1'b0, -1);
    probe_req++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int t0;
    rst_n = 1;
    sw = 10'h3FF;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    mon_en = 1;
    repeat (5) @(negedge clk);
    // 1: reset mid-cycle with all switches up, then idle
    reset_probe("reset");
    repeat (50) @(negedge clk);
    // 2: basic entry, then switch noise during RUN, then enter back to OPCODE
    step("opc_04", 10'h004, 1, 0, 6'h04, 10'h000, 0, 2'b01, 0);
    step("opd_2e6", 10'h2E6, 1, 0, 6'h04, 10'h2E6, 1, 2'b10, 0);
    repeat (20) begin
      @(negedge clk);
      sw = 10'($urandom);
    end
    repeat (5) @(negedge clk);
    step("run_exit", 10'h155, 1, 0, 6'h04, 10'h2E6, 0, 2'b00, 0);
    // 3: bouncy enter, single commit timed from the final rising edge, long hold
    @(negedge clk);
    sw = 10'h001;
    repeat (3) @(negedge clk);
    t0 = cyc;
    push("bounce", 6'h01, 10'h2E6, 0, 2'b01, 0, t0 + 5 + 7);
    for (int i = 0; i < 6; i++) begin
      btn_enter = bseq[i];
      @(negedge clk);
    end
    repeat (100) @(negedge clk);
    btn_enter = 0;
    repeat (12) @(negedge clk);
    step("clr_opd", 10'h001, 0, 1, 6'h00, 10'h000, 0, 2'b00, 0);
    // 4: illegal opcodes then a legal single-bit opcode
    step("ill_zero", 10'h000, 1, 0, 6'h00, 10'h000, 0, 2'b00, 1);
    step("ill_multi", 10'h021, 1, 0, 6'h00, 10'h000, 0, 2'b00, 1);
    step("opc_20", 10'h020, 1, 0, 6'h20, 10'h000, 0, 2'b01, 0);
    // 5: clear and enter together in OPERAND, then clear alone in RUN
    step("clr_ent", 10'h3FF, 1, 1, 6'h00, 10'h000, 0, 2'b00, 0);
    step("opc_04b", 10'h004, 1, 0, 6'h04, 10'h000, 0, 2'b01, 0);
    step("opd_2e6b", 10'h2E6, 1, 0, 6'h04, 10'h2E6, 1, 2'b10, 0);
    step("clr_run", 10'h2E6, 0, 1, 6'h00, 10'h000, 0, 2'b00, 0);
    // 6: reset while the enter counter is at 2; held button must not fire afterwards
    step("opc_08", 10'h008, 1, 0, 6'h08, 10'h000, 0, 2'b01, 0);
    @(negedge clk);
    btn_enter = 1;
    repeat (3) @(posedge clk);
    reset_probe("reset_mid");
    repeat (20) @(negedge clk);
    btn_enter = 0;
    repeat (20) @(negedge clk);
    step("opc_02", 10'h002, 1, 0, 6'h02, 10'h000, 0, 2'b01, 0);
    repeat (20) @(negedge clk);
    while (q.size() > 0) begin
      ex = q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: got no output event, required op=%h opd=%h v=%b st=%b err=%b", ex.nm, ex.op, ex.opd, ex.v, ex.st, ex.e);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_operand_entry.md
Name: alu_operand_entry

Overview:
- Upstream front end for the ALU.
- Synchronizes and debounces the board switches and two push buttons.
- Runs a two-step entry sequence: opcode first, then operand.
- Presents registered, glitch-free opcode/operand to the ALU, plus a valid flag, so the seven-segment result only updates on deliberate user entry.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before a button level is accepted (5 ms at 50 MHz); legal range ≥ 2
SYNC_STAGES, 2, flip-flop stages in the input synchronizers for sw, btn_enter, btn_clear; legal range ≥ 2

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
sw  input  10  raw slide switches, asynchronous
btn_enter  input  1  raw enter button, active-high, asynchronous, bouncy
btn_clear  input  1  raw clear button, active-high, asynchronous, bouncy
opcode  output  6  latched opcode to ALU
operand  output  10  latched operand to ALU
valid  output  1  high while opcode and operand form a committed pair
entry_state  output  2  FSM state for status LEDs: 00 OPCODE, 01 OPERAND, 10 RUN
err  output  1  one-cycle pulse when an opcode entry is rejected

Behaviour:
- Reset: the design has one clock domain and one reset. rst_n low asynchronously forces:
  - opcode = 0, operand = 0, valid = 0, err = 0, entry_state = OPCODE (00);
  - all synchronizer flops, debounce counters and debounced levels = 0.
  - Reset mid-sequence discards any partial entry.
- Synchronizers: sw, btn_enter and btn_clear each pass through SYNC_STAGES flops. All downstream logic uses only the synchronized values (sw_s, ent_s, clr_s).
- Debounce, one instance per button:
  - counter width = clog2(DEBOUNCE_CYCLES+1).
  - While the synchronized level equals the debounced level, the counter is held at 0.
  - While they differ, the counter increments each cycle.
  - When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips on that edge and the counter clears.
  - Any return to equality before that point clears the counter, so the bounce is rejected.
- Pulses: a press pulse is asserted for exactly one cycle, in the cycle where the debounced level is 1 and its previous-cycle copy is 0. A release generates no pulse. Holding the button yields a single pulse.
- Latency: from the first edge at which ent_s = 1 (held stable), the press pulse is high after DEBOUNCE_CYCLES edges. The FSM and output registers update on the next edge.
- FSM, clear pulse (priority over enter in every state):
  - next state OPCODE; opcode = 0, operand = 0, valid = 0.
  - Simultaneous clear and enter pulses: clear wins, enter is ignored, err = 0.
- FSM, OPCODE state, on enter pulse:
  - sw_s[5:0] has exactly one bit set: opcode ← sw_s[5:0], go to OPERAND.
  - otherwise (zero or multiple bits set): stay in OPCODE, err = 1 for one cycle, opcode unchanged.
- FSM, OPERAND state, on enter pulse: operand ← sw_s[9:0]; valid ← 1; go to RUN. There is no legality check: all 1024 values are accepted.
- FSM, RUN state:
  - opcode and operand are held; switch changes have no effect.
  - On enter pulse: valid ← 0, go to OPCODE. opcode and operand retain their last values until overwritten.
- Outputs: opcode and operand change only on the cycle a new value is committed, never combinationally from sw. entry_state 11 is unreachable; if ever decoded, the FSM goes to OPCODE.
- err is registered and never high for more than one consecutive cycle.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and SYNC_STAGES=2.
1. Reset check: assert rst_n=0 mid-cycle with sw=10'h3FF → outputs immediately 0 and entry_state=00. Release rst_n with no buttons pressed for 50 cycles → no change.
2. Basic entry sequence:
   - sw[5:0]=6'b000100, press enter cleanly → opcode=6'h04, entry_state=01.
   - sw=10'b1011100110, press enter → operand=10'h2E6, valid=1, entry_state=10.
   - Verify opcode/operand unchanged while sw toggles randomly during RUN.
3. Bounce rejection: enter toggles 1,0,1,1,0,1,1,1,1… at the clock boundary → exactly one pulse, only after 4 stable synchronized-high cycles. The commit edge is exactly 2+4+1 edges after the final 0→1 raw transition; the button is held for 100 cycles → still one pulse.
4. Illegal opcode: in OPCODE with sw[5:0]=6'b000000, press enter → err high for 1 cycle, state 00. Repeat with 6'b100001 → same result. Then with 6'b100000 → opcode=6'h20, state 01, err=0.
5. Clear priority: in OPERAND, press clear and enter so both debounced pulses coincide → state 00, opcode=0, operand=0, valid=0, err=0. A clear pressed alone in RUN → same result.
6. Reset mid-debounce: while the enter counter is at 2 in OPERAND state, pulse rst_n low → all outputs zero, state 00, and no pulse is generated after release even with the button still held until re-released and pressed.
